// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Memory-side bus between the data cache (initiator) and dmem_responder.
//   Signals:
//     m_addr           word address from the initiator
//     m_byte_en        write byte enables, bit i selects byte [8i+7:8i]
//     m_read/m_write   request strobes, held by the initiator until accepted
//     m_writedata      write data
//     m_readdata       read data, meaningful while m_readdata_valid=1
//     m_readdata_valid one-cycle pulse per accepted read
//     m_waitrequest    responder busy; requests are not accepted while high
//   Modports: master (cache side), slave (responder side).
interface dmem_responder_if #(
    parameter int unsigned ADDR_W = 26
) ();
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_byte_en;
    logic              m_read;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;
    logic              m_readdata_valid;
    logic              m_waitrequest;

    modport master (
        output m_addr, m_byte_en, m_read, m_write, m_writedata,
        input  m_readdata, m_readdata_valid, m_waitrequest
    );

    modport slave (
        input  m_addr, m_byte_en, m_read, m_write, m_writedata,
        output m_readdata, m_readdata_valid, m_waitrequest
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the data-cache refill/write-back port. Serves
//   single-word reads and byte-masked writes from an internal word-addressed
//   array with configurable read/write wait-state latency.
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset (storage is not cleared)
//     bus   dmem_responder_if.slave request/response bus
//     err   sticky protocol/range error flag, cleared only by rst
//   Optional build macro DMEM_JITTER_EN: adds 0..3 pseudo-random extra wait
//   cycles per request, drawn from an 8-bit LFSR seeded with LFSR_SEED.
module dmem_responder #(
    parameter int unsigned ADDR_W    = 26,
    parameter int unsigned DEPTH_W   = 10,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_LAT = 1,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    dmem_responder_if.slave     bus,
    output logic                err
);

    localparam int unsigned DEPTH    = 1 << DEPTH_W;
    // Busy cycles between acceptance and the response / next acceptance.
    localparam logic [3:0]  RD_BUSY_LEN = 4'(READ_LAT - 1);
    localparam logic [3:0]  WR_BUSY_LEN = 4'(WRITE_LAT - 1);
    localparam bit          CFG_OK   = (READ_LAT >= 1) && (READ_LAT <= 15)
                                    && (WRITE_LAT >= 1) && (WRITE_LAT <= 15)
                                    && (DEPTH_W >= 1) && (ADDR_W > DEPTH_W)
                                    && (LFSR_SEED != 8'h00);

    // Reject illegal configurations at elaboration.
    if (!CFG_OK) begin : g_bad_cfg
        $error("dmem_responder: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        RD_RESP = 2'd2,
        WR_BUSY = 2'd3
    } state_t;

    state_t             state;
    logic [3:0]         lat_cnt;
    logic [DEPTH_W-1:0] rd_idx;
    logic               rd_oor;
    logic [31:0]        mem [DEPTH];

    logic               accept_c;
    logic               oor_c;
    logic               wr_en_c;
    logic [DEPTH_W-1:0] idx_c;
    logic               rd_busy_c;
    logic               wr_busy_c;
    logic [3:0]         rd_cnt_ld_c;
    logic [3:0]         wr_cnt_ld_c;
    logic               busy_done_c;

    assign idx_c    = bus.m_addr[DEPTH_W-1:0];
    assign oor_c    = |bus.m_addr[ADDR_W-1:DEPTH_W];
    assign accept_c = (state == IDLE) && !bus.m_waitrequest
                    && (bus.m_read || bus.m_write);
    // Simultaneous read+write is served as a write; out-of-range writes are dropped.
    assign wr_en_c  = accept_c && bus.m_write && !oor_c;

`ifdef DMEM_JITTER_EN
    logic [7:0] lfsr;
    logic [1:0] jit_cnt;
    logic [1:0] extra_c;
    logic [1:0] rd_jit_ld_c;
    logic [1:0] wr_jit_ld_c;

    assign extra_c = lfsr[1:0];

    // Fibonacci LFSR, taps 8,6,5,4; free-running.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Busy time = base + extra, split as (lat_cnt+1) base cycles then jit_cnt
    // extra cycles, so the 4-bit counter never has to hold more than 13.
    always_comb begin
        rd_busy_c   = (RD_BUSY_LEN != 4'd0) || (extra_c != 2'd0);
        wr_busy_c   = (WR_BUSY_LEN != 4'd0) || (extra_c != 2'd0);
        rd_cnt_ld_c = 4'd0;
        wr_cnt_ld_c = 4'd0;
        rd_jit_ld_c = extra_c - 2'd1;
        wr_jit_ld_c = extra_c - 2'd1;
        if (RD_BUSY_LEN != 4'd0) begin
            rd_cnt_ld_c = RD_BUSY_LEN - 4'd1;
            rd_jit_ld_c = extra_c;
        end
        if (WR_BUSY_LEN != 4'd0) begin
            wr_cnt_ld_c = WR_BUSY_LEN - 4'd1;
            wr_jit_ld_c = extra_c;
        end
        busy_done_c = (lat_cnt == 4'd0) && (jit_cnt == 2'd0);
    end
`else
    // lat_cnt holds remaining busy cycles minus one.
    always_comb begin
        rd_busy_c   = (RD_BUSY_LEN != 4'd0);
        wr_busy_c   = (WR_BUSY_LEN != 4'd0);
        rd_cnt_ld_c = RD_BUSY_LEN - 4'd1;
        wr_cnt_ld_c = WR_BUSY_LEN - 4'd1;
        busy_done_c = (lat_cnt == 4'd0);
    end
`endif

    // Storage: byte-masked write at acceptance, never reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_c) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.m_byte_en[i]) begin
                    mem[idx_c][8*i +: 8] <= bus.m_writedata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            lat_cnt              <= 4'd0;
            rd_idx               <= '0;
            rd_oor               <= 1'b0;
            err                  <= 1'b0;
            bus.m_waitrequest    <= 1'b0;
            bus.m_readdata_valid <= 1'b0;
            bus.m_readdata       <= 32'h0;
`ifdef DMEM_JITTER_EN
            jit_cnt              <= 2'd0;
`endif
        end else begin
            bus.m_readdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if ((bus.m_read && bus.m_write) || oor_c) begin
                            err <= 1'b1;
                        end
                        if (bus.m_write) begin
                            if (wr_busy_c) begin
                                state             <= WR_BUSY;
                                bus.m_waitrequest <= 1'b1;
                                lat_cnt           <= wr_cnt_ld_c;
`ifdef DMEM_JITTER_EN
                                jit_cnt           <= wr_jit_ld_c;
`endif
                            end
                        end else begin
                            rd_idx            <= idx_c;
                            rd_oor            <= oor_c;
                            bus.m_waitrequest <= 1'b1;
                            if (rd_busy_c) begin
                                state   <= RD_BUSY;
                                lat_cnt <= rd_cnt_ld_c;
`ifdef DMEM_JITTER_EN
                                jit_cnt <= rd_jit_ld_c;
`endif
                            end else begin
                                state                <= RD_RESP;
                                bus.m_readdata_valid <= 1'b1;
                                bus.m_readdata       <= oor_c ? 32'h0 : mem[idx_c];
                            end
                        end
                    end
                end
                RD_BUSY: begin
                    if (busy_done_c) begin
                        state                <= RD_RESP;
                        bus.m_readdata_valid <= 1'b1;
                        bus.m_readdata       <= rd_oor ? 32'h0 : mem[rd_idx];
                    end else if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
`ifdef DMEM_JITTER_EN
                    else begin
                        jit_cnt <= jit_cnt - 2'd1;
                    end
`endif
                end
                RD_RESP: begin
                    state             <= IDLE;
                    bus.m_waitrequest <= 1'b0;
                end
                WR_BUSY: begin
                    if (busy_done_c) begin
                        state             <= IDLE;
                        bus.m_waitrequest <= 1'b0;
                    end else if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
`ifdef DMEM_JITTER_EN
                    else begin
                        jit_cnt <= jit_cnt - 2'd1;
                    end
`endif
                end
                default: begin
                    state             <= IDLE;
                    bus.m_waitrequest <= 1'b0;
                end
            endcase
        end
    end

endmodule
